// File: rtl/image_proc_pkg.sv
// Shared types and constants for the image-processing pixel pipeline.
// Holds the dark-level corrector FSM encoding and the dark-run averaging shift.
package image_proc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDark,
    StColor,
    StFlush
  } dlc_state_e;

  localparam int unsigned DefaultDarkPixels = 16;
  localparam int unsigned DARK_SHIFT        = $clog2(DefaultDarkPixels);

  // Averaging over a power-of-two dark run is a plain right shift by this amount.
  function automatic int unsigned dark_shift(input int unsigned dark_pixels);
    return $clog2(dark_pixels);
  endfunction

endpackage

// File: rtl/dark_level_corrector_if.sv
// Signal bundle for a dark_level_corrector instance: sensor-side controls plus corrected output.
// The block itself keeps discrete ports; integrations wire them through this bundle.
interface dark_level_corrector_if #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned INDEX_WIDTH = 12
);

  logic                   enable;
  logic                   line_valid;
  logic [DATA_WIDTH-1:0]  data_in;
  logic                   error_clear;
  logic [DATA_WIDTH-1:0]  data_out;
  logic                   data_valid;
  logic [INDEX_WIDTH-1:0] pixel_index;
  logic                   line_start;
  logic                   line_end;
  logic [DATA_WIDTH-1:0]  dark_level;
  logic                   underrun;
  logic                   overrun;

  modport master (
    output enable, line_valid, data_in, error_clear,
    input  data_out, data_valid, pixel_index, line_start, line_end, dark_level, underrun, overrun
  );

  modport slave (
    input  enable, line_valid, data_in, error_clear,
    output data_out, data_valid, pixel_index, line_start, line_end, dark_level, underrun, overrun
  );

endinterface

// File: rtl/sat_subtractor.sv
// Combinational a - b clamped at zero, used to remove the black level from a pixel.
module sat_subtractor #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] minuend_i,
  input  logic [DATA_WIDTH-1:0] subtrahend_i,
  output logic [DATA_WIDTH-1:0] diff_o
);

  always_comb begin
    diff_o = '0;
    if (minuend_i > subtrahend_i) begin
      diff_o = minuend_i - subtrahend_i;
    end
  end

endmodule

// File: rtl/dark_level_corrector.sv
// Per-line black-level estimation from leading dark pixels, subtracted from the active pixels.
// Tracks line framing and flags lines that end early (underrun) or run long (overrun).
module dark_level_corrector
  import image_proc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH             = 8,
  parameter int unsigned TAP_DARK_PIXELS_COUNT  = 16,
  parameter int unsigned TAP_COLOR_PIXELS_COUNT = 1024,
  parameter int unsigned INDEX_WIDTH            = 12
) (
  input  logic                   pixel_clock,
  input  logic                   aresetn,
  input  logic                   enable,
  input  logic                   line_valid,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   error_clear,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   data_valid,
  output logic [INDEX_WIDTH-1:0] pixel_index,
  output logic                   line_start,
  output logic                   line_end,
  output logic [DATA_WIDTH-1:0]  dark_level,
  output logic                   underrun,
  output logic                   overrun
);

  localparam int unsigned DarkShift = dark_shift(TAP_DARK_PIXELS_COUNT);
  localparam int unsigned SumWidth  = DATA_WIDTH + DarkShift;
  localparam logic [INDEX_WIDTH-1:0] LastIndex = INDEX_WIDTH'(TAP_COLOR_PIXELS_COUNT - 1);

  dlc_state_e             state_q, state_d;
  logic                   lv_prev_q, lv_prev_d;
  logic [SumWidth-1:0]    sum_q, sum_d;
  logic [DarkShift-1:0]   dark_cnt_q, dark_cnt_d;
  logic [INDEX_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
  logic                   color_done_q, color_done_d;
  logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
  logic                   data_valid_q, data_valid_d;
  logic [INDEX_WIDTH-1:0] pixel_index_q, pixel_index_d;
  logic                   line_start_q, line_start_d;
  logic                   line_end_q, line_end_d;
  logic [DATA_WIDTH-1:0]  dark_level_q, dark_level_d;
  logic                   underrun_q, underrun_d;
  logic                   overrun_q, overrun_d;

  logic [SumWidth-1:0]    sum_acc;
  logic [DATA_WIDTH-1:0]  corrected;

  assign sum_acc = sum_q + SumWidth'(data_in);

  sat_subtractor #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sat_subtractor (
    .minuend_i   (data_in),
    .subtrahend_i(dark_level_q),
    .diff_o      (corrected)
  );

  always_comb begin
    state_d       = state_q;
    lv_prev_d     = line_valid;
    sum_d         = sum_q;
    dark_cnt_d    = dark_cnt_q;
    pix_cnt_d     = pix_cnt_q;
    color_done_d  = color_done_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    pixel_index_d = pixel_index_q;
    line_start_d  = 1'b0;
    line_end_d    = 1'b0;
    dark_level_d  = dark_level_q;
    // Clear first so an error raised in the same cycle overrides it.
    underrun_d    = error_clear ? 1'b0 : underrun_q;
    overrun_d     = error_clear ? 1'b0 : overrun_q;

    unique case (state_q)
      StIdle: begin
        if (line_valid && !lv_prev_q && enable) begin
          state_d    = StDark;
          sum_d      = SumWidth'(data_in);
          dark_cnt_d = DarkShift'(1);
        end
      end

      StDark: begin
        if (!line_valid) begin
          underrun_d = 1'b1;
          state_d    = StIdle;
        end else begin
          sum_d      = sum_acc;
          dark_cnt_d = dark_cnt_q + 1'b1;
          if (dark_cnt_q == '1) begin
            dark_level_d = sum_acc[DarkShift +: DATA_WIDTH];
            pix_cnt_d    = '0;
            color_done_d = 1'b0;
            state_d      = StColor;
          end
        end
      end

      StColor: begin
        // Once the last active pixel is out, the following beat decides clean end vs overrun.
        if (color_done_q) begin
          if (line_valid) begin
            overrun_d = 1'b1;
            state_d   = StFlush;
          end else begin
            state_d   = StIdle;
          end
        end else if (!line_valid) begin
          underrun_d = 1'b1;
          state_d    = StIdle;
        end else begin
          data_out_d    = corrected;
          data_valid_d  = 1'b1;
          pixel_index_d = pix_cnt_q;
          line_start_d  = (pix_cnt_q == '0);
          if (pix_cnt_q == LastIndex) begin
            line_end_d   = 1'b1;
            color_done_d = 1'b1;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end
      end

      StFlush: begin
        if (!line_valid) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // lv_prev resets high so a line already active at reset release is not taken as a new edge.
  always_ff @(posedge pixel_clock or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= StIdle;
      lv_prev_q     <= 1'b1;
      sum_q         <= '0;
      dark_cnt_q    <= '0;
      pix_cnt_q     <= '0;
      color_done_q  <= 1'b0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      pixel_index_q <= '0;
      line_start_q  <= 1'b0;
      line_end_q    <= 1'b0;
      dark_level_q  <= '0;
      underrun_q    <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      lv_prev_q     <= lv_prev_d;
      sum_q         <= sum_d;
      dark_cnt_q    <= dark_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      color_done_q  <= color_done_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      pixel_index_q <= pixel_index_d;
      line_start_q  <= line_start_d;
      line_end_q    <= line_end_d;
      dark_level_q  <= dark_level_d;
      underrun_q    <= underrun_d;
      overrun_q     <= overrun_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign pixel_index = pixel_index_q;
  assign line_start  = line_start_q;
  assign line_end    = line_end_q;
  assign dark_level  = dark_level_q;
  assign underrun    = underrun_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_dark_level_corrector.sv
// Self-checking bench for dark_level_corrector: directed and random lines against a
// line-level reference model (dark average, clamped subtraction, framing, sticky flags).
module tb_dark_level_corrector;

  localparam int DW = 8;
  localparam int ND = 16;
  localparam int NC = 1024;
  localparam int IW = 12;

  logic pixel_clock = 1'b0;
  logic aresetn     = 1'b0;

  always #5 pixel_clock = ~pixel_clock;

  dark_level_corrector_if #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dif ();

  dark_level_corrector #(
    .DATA_WIDTH            (DW),
    .TAP_DARK_PIXELS_COUNT (ND),
    .TAP_COLOR_PIXELS_COUNT(NC),
    .INDEX_WIDTH           (IW)
  ) dut (
    .pixel_clock(pixel_clock),
    .aresetn    (aresetn),
    .enable     (dif.enable),
    .line_valid (dif.line_valid),
    .data_in    (dif.data_in),
    .error_clear(dif.error_clear),
    .data_out   (dif.data_out),
    .data_valid (dif.data_valid),
    .pixel_index(dif.pixel_index),
    .line_start (dif.line_start),
    .line_end   (dif.line_end),
    .dark_level (dif.dark_level),
    .underrun   (dif.underrun),
    .overrun    (dif.overrun)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  int pix[$];
  int exp_dark  = 0;
  int exp_last  = 0;
  bit exp_under = 1'b0;
  bit exp_over  = 1'b0;

  task automatic tick();
    @(posedge pixel_clock);
    #1;
  endtask

  task automatic fill_line(input int len, input int dval, input int cval);
    pix.delete();
    for (int i = 0; i < len; i++) begin
      if (i < ND) pix.push_back((dval < 0) ? int'($urandom_range(0, 255)) : dval);
      else        pix.push_back((cval < 0) ? int'($urandom_range(0, 255)) : cval);
    end
  endtask

  // Plays pix[] as one line (low lead-in, beats, one low trailing beat) and checks every beat.
  task automatic play_line(input bit en, input bit drop_en, input bit clr_end);
    int len;
    int new_dark;
    int ei;
    bit ev, es, ee;
    len      = pix.size();
    new_dark = exp_dark;
    if (en && len >= ND) begin
      int s;
      s = 0;
      for (int i = 0; i < ND; i++) s += pix[i];
      new_dark = s / ND;
    end
    dif.line_valid  = 1'b0;
    dif.enable      = en;
    dif.error_clear = 1'b0;
    tick();
    for (int k = 0; k < len; k++) begin
      dif.line_valid = 1'b1;
      dif.data_in    = DW'(pix[k]);
      if (drop_en && k == 3) dif.enable = 1'b0;
      tick();
      ev = 1'b0; es = 1'b0; ee = 1'b0; ei = 0;
      if (en) begin
        if (k == ND - 1) exp_dark = new_dark;
        if (k >= ND && k < ND + NC) begin
          ev       = 1'b1;
          ei       = k - ND;
          es       = (ei == 0);
          ee       = (ei == NC - 1);
          exp_last = (pix[k] > new_dark) ? pix[k] - new_dark : 0;
        end
        if (k == ND + NC) exp_over = 1'b1;
      end
      n_vec++;
      if (dif.data_valid !== ev || dif.data_out !== DW'(exp_last)) begin
        n_bad++;
        $display("FAIL beat%0d_data: valid=%b data_out=%0d, required valid=%b data_out=%0d",
                 k, dif.data_valid, dif.data_out, ev, exp_last);
      end
      n_vec++;
      if (dif.line_start !== es || dif.line_end !== ee || (ev && dif.pixel_index !== IW'(ei))) begin
        n_bad++;
        $display("FAIL beat%0d_frame: start=%b end=%b index=%0d, required start=%b end=%b index=%0d",
                 k, dif.line_start, dif.line_end, dif.pixel_index, es, ee, ei);
      end
      n_vec++;
      if (dif.dark_level !== DW'(exp_dark) || dif.underrun !== exp_under
          || dif.overrun !== exp_over) begin
        n_bad++;
        $display("FAIL beat%0d_status: dark=%0d under=%b over=%b, required dark=%0d under=%b over=%b",
                 k, dif.dark_level, dif.underrun, dif.overrun, exp_dark, exp_under, exp_over);
      end
    end
    dif.line_valid  = 1'b0;
    dif.error_clear = clr_end;
    tick();
    dif.error_clear = 1'b0;
    if (clr_end) begin
      exp_under = 1'b0;
      exp_over  = 1'b0;
    end
    if (en && len < ND + NC) exp_under = 1'b1;
    n_vec++;
    if (dif.underrun !== exp_under || dif.overrun !== exp_over || dif.data_valid !== 1'b0
        || dif.line_end !== 1'b0 || dif.dark_level !== DW'(exp_dark)) begin
      n_bad++;
      $display("FAIL line_tail: under=%b over=%b valid=%b end=%b dark=%0d, required %b %b 0 0 %0d",
               dif.underrun, dif.overrun, dif.data_valid, dif.line_end, dif.dark_level,
               exp_under, exp_over, exp_dark);
    end
    dif.enable = 1'b1;
  endtask

  task automatic test_reset();
    aresetn         = 1'b0;
    dif.enable      = 1'b0;
    dif.line_valid  = 1'b0;
    dif.data_in     = '0;
    dif.error_clear = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({dif.data_out, dif.data_valid, dif.pixel_index, dif.line_start, dif.line_end,
         dif.dark_level, dif.underrun, dif.overrun} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: out=%0d valid=%b idx=%0d dark=%0d under=%b over=%b, required 0",
               dif.data_out, dif.data_valid, dif.pixel_index, dif.dark_level, dif.underrun,
               dif.overrun);
    end
    aresetn    = 1'b1;
    dif.enable = 1'b1;
    tick();
  endtask

  task automatic test_nominal();
    fill_line(ND + NC, 20, 100);
    play_line(1'b1, 1'b0, 1'b0);
    n_vec++;
    if (dif.dark_level !== 8'd20) begin
      n_bad++;
      $display("FAIL nominal_dark: dark_level=%0d, required 20", dif.dark_level);
    end
  endtask

  task automatic test_saturation();
    fill_line(ND + NC, 50, -1);
    pix[ND] = 30;
    pix[ND + 1] = 50;
    play_line(1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_alternating();
    fill_line(ND + NC, 0, -1);
    for (int i = 0; i < ND; i++) pix[i] = (i % 2 == 0) ? 10 : 13;
    play_line(1'b1, 1'b0, 1'b0);
    n_vec++;
    if (dif.dark_level !== 8'd11) begin
      n_bad++;
      $display("FAIL alternating_dark: dark_level=%0d, required 11", dif.dark_level);
    end
  endtask

  task automatic test_underrun();
    fill_line(ND + 500, -1, -1);
    play_line(1'b1, 1'b0, 1'b0);
    fill_line(ND + NC, -1, -1);
    play_line(1'b1, 1'b0, 1'b0);
    // Short line dying in the dark run while error_clear is held: the new error must stick.
    fill_line(5, -1, -1);
    play_line(1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_overrun();
    fill_line(ND + NC + 10, -1, -1);
    play_line(1'b1, 1'b0, 1'b1);
    fill_line(ND + NC + 10, -1, -1);
    play_line(1'b1, 1'b0, 1'b0);
    dif.error_clear = 1'b1;
    tick();
    dif.error_clear = 1'b0;
    exp_under = 1'b0;
    exp_over  = 1'b0;
    n_vec++;
    if (dif.overrun !== 1'b0 || dif.underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL error_clear: over=%b under=%b, required 0 0", dif.overrun, dif.underrun);
    end
  endtask

  task automatic test_enable_gate();
    fill_line(ND + 40, -1, -1);
    play_line(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int len;
      case ($urandom_range(0, 2))
        0:       len = ND + NC;
        1:       len = int'($urandom_range(1, ND + NC - 1));
        default: len = ND + NC + int'($urandom_range(1, 8));
      endcase
      fill_line(len, -1, -1);
      play_line(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_midline();
    fill_line(ND + NC, -1, -1);
    dif.line_valid = 1'b0;
    dif.enable     = 1'b1;
    tick();
    for (int k = 0; k <= ND + 300; k++) begin
      dif.line_valid = 1'b1;
      dif.data_in    = DW'(pix[k]);
      tick();
    end
    #2;
    aresetn = 1'b0;
    #1;
    exp_dark  = 0;
    exp_last  = 0;
    exp_under = 1'b0;
    exp_over  = 1'b0;
    n_vec++;
    if ({dif.data_out, dif.data_valid, dif.pixel_index, dif.line_start, dif.line_end,
         dif.dark_level, dif.underrun, dif.overrun} !== '0) begin
      n_bad++;
      $display("FAIL midline_reset: out=%0d valid=%b idx=%0d dark=%0d, required all 0",
               dif.data_out, dif.data_valid, dif.pixel_index, dif.dark_level);
    end
    #1;
    aresetn = 1'b1;
    for (int k = ND + 301; k < ND + 400; k++) begin
      dif.data_in = DW'(pix[k]);
      tick();
      n_vec++;
      if (dif.data_valid !== 1'b0 || dif.dark_level !== '0) begin
        n_bad++;
        $display("FAIL post_reset_beat%0d: valid=%b dark=%0d, required valid=0 dark=0",
                 k, dif.data_valid, dif.dark_level);
      end
    end
    dif.line_valid = 1'b0;
    tick();
    n_vec++;
    if (dif.underrun !== 1'b0 || dif.overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_flags: under=%b over=%b, required 0 0", dif.underrun, dif.overrun);
    end
    fill_line(ND + NC, -1, -1);
    play_line(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_saturation();
    test_alternating();
    test_underrun();
    test_overrun();
    test_enable_gate();
    test_random();
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
